sparse_matmul_engine: RTL and testbench

Parametrised successor to the fixed 3x3 / 8-bit demo datapath: one-shot N x N unsigned matrix multiply C = A x B, started by a falling edge on w.
- Sequential MAC with zero-operand gating and a zero-skip counter for sparsity stats.
- Results land in a DEPTH-deep circular history buffer with registered read-back.
- Sits between the board-level button/switch inputs and the display/readout logic.

---
 rtl/sparse_mm_pkg.sv | 28 ++
 rtl/sparse_mm_history.sv | 61 ++++++
 rtl/sparse_matmul_engine.sv | 169 ++++++++++++++++
 tb/tb_sparse_matmul_engine.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_mm_pkg.sv
// Shared state encoding and arithmetic helpers for the sparse matrix-multiply engine.
// Defining SPARSE_MM_SAT_EN makes result narrowing saturate instead of wrap.
package sparse_mm_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      MAC   = 3'd2,
      STORE = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Worst-case sum of n products of two data_w-bit operands.
   function automatic int acc_width(input int data_w, input int n);
      return 2 * data_w + $clog2(n);
   endfunction

   function automatic logic [63:0] fit_result(input logic [63:0] sum, input int data_w);
      logic [63:0] max_val;
      max_val = (64'd1 << data_w) - 64'd1;
`ifdef SPARSE_MM_SAT_EN
      return (sum > max_val) ? max_val : sum;
`else
      return sum & max_val;
`endif
   endfunction

endpackage

// File: rtl/sparse_mm_history.sv
// Circular history of result snapshots with a registered read-back mux.
// The read register samples post-write state, so a same-cycle store is visible on the next cycle.
module sparse_mm_history
   import sparse_mm_pkg::*;
#(
   parameter int N      = 3,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
)
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [N*N-1:0][DATA_W-1:0]    wr_data,
   input  logic [$clog2(DEPTH)-1:0]      rd_idx,
   output logic [N*N-1:0][DATA_W-1:0]    rd_data,
   output logic                          rd_valid,
   output logic [$clog2(DEPTH):0]        hist_cnt
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef logic [N*N-1:0][DATA_W-1:0] snap_t;

   snap_t            mem [DEPTH];
   snap_t            rd_word;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] ptr_nxt;
   logic [PTR_W-1:0] slot_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             hit;

   always_comb begin
      ptr_nxt = wr_en ? wr_ptr + PTR_W'(1) : wr_ptr;
      cnt_nxt = hist_cnt;
      if (wr_en && (hist_cnt != CNT_W'(DEPTH)))
         cnt_nxt = hist_cnt + CNT_W'(1);
      slot_nxt = ptr_nxt - PTR_W'(1) - rd_idx;
      hit      = ({1'b0, rd_idx} < cnt_nxt);
      rd_word  = (wr_en && (slot_nxt == wr_ptr)) ? wr_data : mem[slot_nxt];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < DEPTH; s++)
            mem[s] <= '0;
         wr_ptr   <= '0;
         hist_cnt <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (wr_en)
            mem[wr_ptr] <= wr_data;
         wr_ptr   <= ptr_nxt;
         hist_cnt <= cnt_nxt;
         rd_valid <= hit;
         rd_data  <= hit ? rd_word : '0;
      end
   end

endmodule

// File: rtl/sparse_matmul_engine.sv
// One-shot N x N unsigned matrix multiply with zero-operand skipping and result history.
// SPARSE_MM_SAT_EN (see sparse_mm_pkg) selects saturating result narrowing.
//
// state | meaning
// IDLE  | waiting for a falling edge on w
// LOAD  | capture A/B, clear accumulator, indices and skip count
// MAC   | one (i,j,k) multiply-accumulate per cycle, k innermost
// STORE | push finished C into the history buffer
// DONE  | one-cycle completion pulse
module sparse_matmul_engine
   import sparse_mm_pkg::*;
#(
   parameter int N      = 3,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
)
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          w,
   input  logic [N*N-1:0][DATA_W-1:0]    a_mat,
   input  logic [N*N-1:0][DATA_W-1:0]    b_mat,
   input  logic [$clog2(DEPTH)-1:0]      rd_idx,
   output logic [N*N-1:0][DATA_W-1:0]    rd_data,
   output logic                          rd_valid,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(DEPTH):0]        hist_cnt,
   output logic [$clog2(N*N*N):0]        skip_cnt
);
   localparam int ACC_W = acc_width(DATA_W, N);
   localparam int IDX_W = $clog2(N);
   localparam int SEL_W = $clog2(N*N);
   localparam int SKP_W = $clog2(N*N*N) + 1;

   state_t                     state;
   state_t                     state_nxt;
   logic                       w_q;
   logic                       start_q;
   logic                       store_en;
   logic [N*N-1:0][DATA_W-1:0] a_q;
   logic [N*N-1:0][DATA_W-1:0] b_q;
   logic [N*N-1:0][DATA_W-1:0] c_q;
   logic [ACC_W-1:0]           acc;
   logic [ACC_W-1:0]           prod;
   logic [ACC_W-1:0]           acc_sum;
   logic [DATA_W-1:0]          a_op;
   logic [DATA_W-1:0]          b_op;
   logic [DATA_W-1:0]          c_next;
   logic [IDX_W-1:0]           i;
   logic [IDX_W-1:0]           j;
   logic [IDX_W-1:0]           k;
   logic [SEL_W-1:0]           a_sel;
   logic [SEL_W-1:0]           b_sel;
   logic [SEL_W-1:0]           c_sel;
   logic                       last_k;
   logic                       last_j;
   logic                       last_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_q) state_nxt = LOAD;
         LOAD:    state_nxt = MAC;
         MAC:     if (last_k && last_j && last_i) state_nxt = STORE;
         STORE:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      store_en = 1'b0;
      case (state)
         LOAD, MAC: busy = 1'b1;
         STORE: begin
            busy     = 1'b1;
            store_en = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Zero A-operands never reach the multiplier.
   always_comb begin
      a_sel   = SEL_W'(int'(i) * N + int'(k));
      b_sel   = SEL_W'(int'(k) * N + int'(j));
      c_sel   = SEL_W'(int'(i) * N + int'(j));
      a_op    = a_q[a_sel];
      b_op    = b_q[b_sel];
      prod    = (a_op == '0) ? '0 : ACC_W'(a_op) * ACC_W'(b_op);
      acc_sum = acc + prod;
      c_next  = DATA_W'(fit_result(64'(acc_sum), DATA_W));
      last_k  = (k == IDX_W'(N-1));
      last_j  = (j == IDX_W'(N-1));
      last_i  = (i == IDX_W'(N-1));
   end

   // w_q comes out of reset as if w were already low, so holding w low across reset is not a start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_q      <= 1'b0;
         start_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         acc      <= '0;
         i        <= '0;
         j        <= '0;
         k        <= '0;
         skip_cnt <= '0;
      end else begin
         w_q     <= w;
         start_q <= w_q & ~w;
         if (state == LOAD) begin
            a_q      <= a_mat;
            b_q      <= b_mat;
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            skip_cnt <= '0;
         end else if (state == MAC) begin
            if (a_op == '0)
               skip_cnt <= skip_cnt + SKP_W'(1);
            if (last_k) begin
               c_q[c_sel] <= c_next;
               acc        <= '0;
               k          <= '0;
               if (!last_j) begin
                  j <= j + IDX_W'(1);
               end else begin
                  j <= '0;
                  i <= last_i ? '0 : i + IDX_W'(1);
               end
            end else begin
               acc <= acc_sum;
               k   <= k + IDX_W'(1);
            end
         end
      end
   end

   sparse_mm_history #(
      .N      (N),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_history (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (store_en),
      .wr_data  (c_q),
      .rd_idx   (rd_idx),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .hist_cnt (hist_cnt)
   );

endmodule

// File: tb/tb_sparse_matmul_engine.sv
// Scoreboard bench for sparse_matmul_engine: runs are predicted by a plain-arithmetic model,
// a monitor checks each done pulse; history read-back is checked against a model queue.
`timescale 1ns/1ps
module tb_sparse_matmul_engine;
   localparam int N      = 3;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int NN     = N * N;
   localparam int LAT    = N * N * N + 3;

   typedef logic [NN-1:0][DATA_W-1:0] mat_t;
   typedef struct {
      mat_t   c;
      int     skip;
      int     hcnt;
      longint done_cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       w;
   mat_t       a_mat;
   mat_t       b_mat;
   logic [1:0] rd_idx;
   mat_t       rd_data;
   logic       rd_valid;
   logic       busy;
   logic       done;
   logic [2:0] hist_cnt;
   logic [5:0] skip_cnt;

   exp_t   sb[$];
   mat_t   hist_q[$];
   int     n_cmp = 0;
   int     n_err = 0;
   int     done_seen = 0;
   longint cyc = 0;

   sparse_matmul_engine #(.N(N), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .w        (w),
      .a_mat    (a_mat),
      .b_mat    (b_mat),
      .rd_idx   (rd_idx),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .busy     (busy),
      .done     (done),
      .hist_cnt (hist_cnt),
      .skip_cnt (skip_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic mat_t model_mul(input mat_t a, input mat_t b);
      mat_t        c;
      int unsigned sum;
      c = '0;
      for (int r = 0; r < N; r++) begin
         for (int col = 0; col < N; col++) begin
            sum = 0;
            for (int m = 0; m < N; m++)
               sum += int'(a[r*N+m]) * int'(b[m*N+col]);
`ifdef SPARSE_MM_SAT_EN
            c[r*N+col] = (sum > 255) ? 8'hFF : DATA_W'(sum);
`else
            c[r*N+col] = DATA_W'(sum % 256);
`endif
         end
      end
      return c;
   endfunction

   function automatic int model_skip(input mat_t a);
      int z;
      z = 0;
      for (int x = 0; x < NN; x++)
         if (a[x] == 0) z += N;
      return z;
   endfunction

   function automatic mat_t ident(input int s);
      mat_t m;
      m = '0;
      for (int x = 0; x < N; x++)
         m[x*N+x] = DATA_W'(s);
      return m;
   endfunction

   function automatic mat_t rand_mat(input int zero_pct);
      mat_t m;
      for (int x = 0; x < NN; x++)
         m[x] = (int'($urandom_range(99)) < zero_pct) ? '0 : DATA_W'($urandom_range(255, 1));
      return m;
   endfunction

   // Issues a start; when predict is set the expected result goes to the scoreboard.
   task automatic run(input mat_t a, input mat_t b, input bit predict);
      exp_t e;
      a_mat = a;
      b_mat = b;
      w = 1'b1;
      @(posedge clk); #1;
      if (predict) begin
         hist_q.push_front(model_mul(a, b));
         if (hist_q.size() > DEPTH) void'(hist_q.pop_back());
         e.c        = model_mul(a, b);
         e.skip     = model_skip(a);
         e.hcnt     = hist_q.size();
         e.done_cyc = cyc + 1 + LAT;
         sb.push_back(e);
      end
      w = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(posedge clk); #1;
         t++;
         if (t == 6) begin
            a_mat = mat_t'({$urandom(), $urandom(), $urandom()});
            b_mat = mat_t'({$urandom(), $urandom(), $urandom()});
         end
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL run_timeout: %0d runs outstanding, expected 0", sb.size());
         sb.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_history();
      mat_t exp_d;
      for (int r = 0; r < DEPTH; r++) begin
         rd_idx = 2'(r);
         repeat (2) @(posedge clk);
         #1;
         exp_d = (r < hist_q.size()) ? hist_q[r] : '0;
         check($sformatf("hist_data[%0d]", r), 128'(rd_data), 128'(exp_d));
         check($sformatf("hist_valid[%0d]", r), 128'(rd_valid), 128'(r < hist_q.size()));
      end
      rd_idx = '0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
         done_seen++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, expected no run pending", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_latency", 128'(cyc), 128'(e.done_cyc));
            check("busy_at_done", 128'(busy), 128'(0));
            check("skip_cnt", 128'(skip_cnt), 128'(e.skip));
            check("hist_cnt", 128'(hist_cnt), 128'(e.hcnt));
            @(posedge clk); #1;
            check("result", 128'(rd_data), 128'(e.c));
            check("result_valid", 128'(rd_valid), 128'(1));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      mat_t b19;
      int   d0;
      reset  = 1'b1;
      w      = 1'b1;
      a_mat  = '0;
      b_mat  = '0;
      rd_idx = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_hist_cnt", 128'(hist_cnt), 128'(0));
      check("rst_skip_cnt", 128'(skip_cnt), 128'(0));
      check("rst_rd_valid", 128'(rd_valid), 128'(0));
      check("rst_rd_data", 128'(rd_data), 128'(0));
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("no_start_after_rst", 128'(busy), 128'(0));

      // identity times 1..9
      for (int x = 0; x < NN; x++) b19[x] = DATA_W'(x + 1);
      run(ident(1), b19, 1'b1);
      wait_done();
      check_history();

      // dense overflow case
      run({NN{8'd16}}, {NN{8'd16}}, 1'b1);
      wait_done();

      // history wrap with scaled identities
      for (int s = 1; s <= 5; s++) begin
         run(ident(1), ident(s), 1'b1);
         wait_done();
      end
      check_history();

      // random sparse operands
      for (int n = 0; n < 8; n++) begin
         run(rand_mat(20 + 10 * (n % 5)), rand_mat(10), 1'b1);
         wait_done();
      end
      check_history();

      // falling edges on w during MAC are ignored
      d0 = done_seen;
      run(rand_mat(30), rand_mat(0), 1'b1);
      repeat (8) @(posedge clk);
      for (int t = 0; t < 3; t++) begin
         #1 w = 1'b1;
         @(posedge clk);
         #1 w = 1'b0;
         @(posedge clk);
      end
      wait_done();
      repeat (40) @(posedge clk);
      #1;
      check("toggle_single_done", 128'(done_seen - d0), 128'(1));
      check("toggle_hist_cnt", 128'(hist_cnt), 128'(hist_q.size()));

      // reset during MAC, with w held low through release
      d0 = done_seen;
      run(rand_mat(30), rand_mat(0), 1'b0);
      repeat (12) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      hist_q.delete();
      check("midrst_busy", 128'(busy), 128'(0));
      check("midrst_hist_cnt", 128'(hist_cnt), 128'(0));
      check("midrst_skip_cnt", 128'(skip_cnt), 128'(0));
      check("midrst_rd_data", 128'(rd_data), 128'(0));
      check("midrst_rd_valid", 128'(rd_valid), 128'(0));
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("midrst_no_done", 128'(done_seen - d0), 128'(0));
      check("w_low_no_start", 128'(busy), 128'(0));
      w = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("w_rise_no_start", 128'(busy), 128'(0));
      check("w_rise_no_done", 128'(done_seen - d0), 128'(0));
      run(ident(2), b19, 1'b1);
      wait_done();
      check_history();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
